// File: rtl/riio_seq_pkg.sv
// Shared types and sizing helpers for the IO-ring supply sequencer.
package riio_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_PWR_UP,
    ST_SETTLE,
    ST_ISO_REL,
    ST_ON,
    ST_ISO_SET,
    ST_PWR_DN
  } seq_state_e;

  localparam int unsigned DEF_SETTLE_CYC  = 16;
  localparam int unsigned DEF_TIMEOUT_CYC = 1024;

  // Width of a segment index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/riio_sync2.sv
// Two-flop synchroniser for asynchronous level inputs; clears to 0 on reset.
module riio_sync2 #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/riio_supply_seq.sv
// Sequences pad-ring supply segments up in ascending and down in descending
// order, with power-up timeout and supply-loss faults.
module riio_supply_seq
  import riio_seq_pkg::*;
#(
  parameter int unsigned NSEG        = 4,
  parameter int unsigned SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         on_req_i,
  input  logic [NSEG-1:0]              seg_pwrok_i,
  output logic [NSEG-1:0]              seg_pwr_en_o,
  output logic [NSEG-1:0]              seg_iso_o,
  output logic                         ring_ready_o,
  output logic                         busy_o,
  output logic                         fault_o,
  output logic [idx_width(NSEG)-1:0]   fault_seg_o
);

  localparam int unsigned IW   = idx_width(NSEG);
  localparam int unsigned MAXC = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  seq_state_e      state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NSEG-1:0] pwr_en_q, pwr_en_d;
  logic [NSEG-1:0] iso_q, iso_d;
  logic            ready_q, ready_d;
  logic            fault_q, fault_d;
  logic [IW-1:0]   fseg_q, fseg_d;
  logic            busy_q;

  logic [NSEG-1:0] pwrok_s;
  logic            any_lost;
  logic [IW-1:0]   lost_idx;
  logic            enter_down;
  logic [IW-1:0]   down_idx;

  riio_sync2 #(.W(NSEG)) u_pwrok_sync (
    .clk (clk),
    .rst (rst),
    .d_i (seg_pwrok_i),
    .q_o (pwrok_s)
  );

  // Lowest-index segment whose synchronised supply-OK has dropped.
  always_comb begin
    any_lost = ~&pwrok_s;
    lost_idx = '0;
    for (int k = int'(NSEG) - 1; k >= 0; k--) begin
      if (!pwrok_s[k]) lost_idx = IW'(k);
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    pwr_en_d   = pwr_en_q;
    iso_d      = iso_q;
    ready_d    = ready_q;
    fault_d    = fault_q;
    fseg_d     = fseg_q;
    enter_down = 1'b0;
    down_idx   = idx_q;

    case (state_q)
      ST_OFF: begin
        if (fault_q) begin
          if (!on_req_i) begin
            fault_d = 1'b0;
            fseg_d  = '0;
          end
        end else if (on_req_i) begin
          state_d     = ST_PWR_UP;
          idx_d       = '0;
          cnt_d       = '0;
          pwr_en_d[0] = 1'b1;
        end
      end
      ST_PWR_UP: begin
        cnt_d = cnt_q + CW'(1);
        if (!on_req_i) begin
          enter_down = 1'b1;
        end else if ((cnt_q != '0) && pwrok_s[idx_q]) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          fault_d    = 1'b1;
          fseg_d     = idx_q;
          enter_down = 1'b1;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q + CW'(1);
        if (!on_req_i) begin
          enter_down = 1'b1;
        end else if (cnt_q == CW'(SETTLE_CYC - 1)) begin
          state_d = ST_ISO_REL;
          cnt_d   = '0;
        end
      end
      ST_ISO_REL: begin
        iso_d[idx_q] = 1'b0;
        if (idx_q != IW'(NSEG - 1)) begin
          pwr_en_d[idx_q + IW'(1)] = 1'b1;
          idx_d   = idx_q + IW'(1);
          cnt_d   = '0;
          state_d = ST_PWR_UP;
        end else begin
          state_d = ST_ON;
          ready_d = 1'b1;
        end
      end
      ST_ON: begin
        if (any_lost) begin
          fault_d    = 1'b1;
          fseg_d     = lost_idx;
          enter_down = 1'b1;
          down_idx   = IW'(NSEG - 1);
        end else if (!on_req_i) begin
          enter_down = 1'b1;
          down_idx   = IW'(NSEG - 1);
        end
      end
      ST_ISO_SET: begin
        iso_d[idx_q]    = 1'b1;
        pwr_en_d[idx_q] = 1'b0;
        ready_d         = 1'b0;
        cnt_d           = '0;
        state_d         = ST_PWR_DN;
      end
      ST_PWR_DN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(SETTLE_CYC - 1)) begin
          cnt_d = '0;
          if (idx_q != '0) begin
            enter_down = 1'b1;
            down_idx   = idx_q - IW'(1);
          end else begin
            state_d = ST_OFF;
          end
        end
      end
      default: state_d = ST_OFF;
    endcase

    // Isolation is raised on the edge entering ISO_SET so the switch-off
    // one edge later always sees an already-isolated segment.
    if (enter_down) begin
      state_d         = ST_ISO_SET;
      idx_d           = down_idx;
      cnt_d           = '0;
      iso_d[down_idx] = 1'b1;
      ready_d         = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_OFF;
      idx_q    <= '0;
      cnt_q    <= '0;
      pwr_en_q <= '0;
      iso_q    <= '1;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
      fseg_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      pwr_en_q <= pwr_en_d;
      iso_q    <= iso_d;
      ready_q  <= ready_d;
      fault_q  <= fault_d;
      fseg_q   <= fseg_d;
      busy_q   <= (state_d != ST_OFF) && (state_d != ST_ON);
    end
  end

  assign seg_pwr_en_o = pwr_en_q;
  assign seg_iso_o    = iso_q;
  assign ring_ready_o = ready_q;
  assign busy_o       = busy_q;
  assign fault_o      = fault_q;
  assign fault_seg_o  = fseg_q;

endmodule
